// File: rtl/gray_pkg.sv
// Shared types, error codes and gray/binary conversions for the gray-code checker.
// The conversions work on GW_MAX bits; callers zero-extend and truncate to their WIDTH.
package gray_pkg;

    localparam int GW_MAX = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        ERROR = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_STALL = 2'b01;
    localparam logic [1:0] ERR_STEP  = 2'b10;
    localparam logic [1:0] ERR_OVF   = 2'b11;

    // Zero upper bits stay zero through both conversions, so one function serves every WIDTH.
    function automatic logic [GW_MAX-1:0] gray2bin(input logic [GW_MAX-1:0] g);
        logic [GW_MAX-1:0] b;
        b[GW_MAX-1] = g[GW_MAX-1];
        for (int i = GW_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [GW_MAX-1:0] bin2gray(input logic [GW_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_checker_gray_next.sv
// Combinational successor of a gray code: the code that follows prev_gray when the
// upstream counter advances by one, wrapping modulo 2^WIDTH.
module gray_next
    import gray_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] prev_gray,
    output logic [WIDTH-1:0] next_gray
);

    logic [WIDTH-1:0] bin_inc;

    always_comb begin
        bin_inc   = WIDTH'(gray2bin(GW_MAX'(prev_gray))) + WIDTH'(1);
        next_gray = WIDTH'(bin2gray(GW_MAX'(bin_inc)));
    end

endmodule

// File: rtl/gray_checker.sv
// Monitors a gray counter's output/overflow against its enable: registers the binary
// value, counts wraps and latches the first protocol violation until cleared.
module gray_checker
    import gray_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int CNTW  = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Clr,
    input  logic             En,
    input  logic [WIDTH-1:0] Gray,
    input  logic             Ovf,
    output logic [WIDTH-1:0] Bin,
    output logic [CNTW-1:0]  Wraps,
    output logic             Locked,
    output logic             Err,
    output logic [1:0]       Err_code
);

    localparam logic [WIDTH-1:0] MAX_GRAY = WIDTH'(bin2gray(GW_MAX'({WIDTH{1'b1}})));

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  prev_gray_reg;
    logic              prev_en_reg;
    logic              wrapped_reg, wrapped_next;
    logic [WIDTH-1:0]  bin_reg;
    logic [CNTW-1:0]   wraps_reg, wraps_next;
    logic              locked_reg;
    logic              err_reg, err_next;
    logic [1:0]        err_code_reg, err_code_next;

    logic [WIDTH-1:0]  expected_gray;
    logic              wrap_hit;
    logic              stall_hit;
    logic              step_hit;
    logic              ovf_hit;
    logic [1:0]        code;

    gray_next #(
        .WIDTH(WIDTH)
    ) u_gray_next (
        .prev_gray (prev_gray_reg),
        .next_gray (expected_gray)
    );

    always_comb begin
        wrap_hit  = prev_en_reg && (prev_gray_reg == MAX_GRAY) && (Gray == '0);
        stall_hit = prev_en_reg && (Gray == prev_gray_reg);
        step_hit  = prev_en_reg ? ((Gray != expected_gray) && (Gray != prev_gray_reg))
                                : (Gray != prev_gray_reg);
        // A wrap seen on this very edge already counts as overflowed.
        ovf_hit   = (Ovf != (wrapped_reg | wrap_hit));

        if (step_hit) begin
            code = ERR_STEP;
        end else if (stall_hit) begin
            code = ERR_STALL;
        end else if (ovf_hit) begin
            code = ERR_OVF;
        end else begin
            code = ERR_NONE;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wrapped_next  = wrapped_reg;
        wraps_next    = wraps_reg;
        err_next      = err_reg;
        err_code_next = err_code_reg;

        case (state_reg)
            IDLE: begin
                wrapped_next = Ovf;
                state_next   = TRACK;
            end
            TRACK: begin
                if (wrap_hit) begin
                    wrapped_next = 1'b1;
                    if (wraps_reg != '1) begin
                        wraps_next = wraps_reg + CNTW'(1);
                    end
                end
                if (code != ERR_NONE) begin
                    state_next    = ERROR;
                    err_next      = 1'b1;
                    err_code_next = code;
                end
            end
            ERROR: begin
                state_next = ERROR;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (Clr) begin
            state_next    = IDLE;
            wrapped_next  = 1'b0;
            wraps_next    = '0;
            err_next      = 1'b0;
            err_code_next = ERR_NONE;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg     <= IDLE;
            prev_gray_reg <= '0;
            prev_en_reg   <= 1'b0;
            wrapped_reg   <= 1'b0;
            bin_reg       <= '0;
            wraps_reg     <= '0;
            locked_reg    <= 1'b0;
            err_reg       <= 1'b0;
            err_code_reg  <= ERR_NONE;
        end else begin
            state_reg     <= state_next;
            prev_gray_reg <= Gray;
            prev_en_reg   <= En;
            wrapped_reg   <= wrapped_next;
            bin_reg       <= WIDTH'(gray2bin(GW_MAX'(Gray)));
            wraps_reg     <= wraps_next;
            locked_reg    <= (state_next == TRACK);
            err_reg       <= err_next;
            err_code_reg  <= err_code_next;
        end
    end

    assign Bin      = bin_reg;
    assign Wraps    = wraps_reg;
    assign Locked   = locked_reg;
    assign Err      = err_reg;
    assign Err_code = err_code_reg;

endmodule

// File: doc/gray_checker.md
Name: gray_checker

Overview:
- Downstream consumer of the 3-bit gray counter; samples the counter's Output and Overflow every Clk edge alongside the counter's En.
- Registers the binary equivalent of each sample, counts wrap-arounds, and flags protocol violations: stall, illegal step, overflow mismatch.
- Runs as a self-check stage in simulation and as a status source for later stages.

Parameters:
- WIDTH, 3, width of the gray code input.
- CNTW, 8, width of the saturating wrap counter.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Clr  input  1  synchronous clear: drops error state, returns to IDLE, zeroes Wraps.
- En  input  1  copy of the counter's enable, same cycle the counter samples it.
- Gray  input  WIDTH  counter Output.
- Ovf  input  1  counter Overflow.
- Bin  output  WIDTH  registered binary of the last sampled Gray.
- Wraps  output  CNTW  number of max-to-0 transitions seen; saturates at all-ones.
- Locked  output  1  high while in TRACK.
- Err  output  1  sticky error flag.
- Err_code  output  2  00 none, 01 stall, 10 illegal step, 11 overflow mismatch.

Behaviour:
- Reset (async, active-high) sets state IDLE, Bin=0, Wraps=0, Locked=0, Err=0, Err_code=00, prev_gray=0, prev_en=0, wrapped=0.
- Every non-reset edge registers prev_gray<=Gray, prev_en<=En, Bin<=gray2bin(Gray).
  - Bin latency is 1 cycle.
  - gray2bin: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i].
- State IDLE:
  - Takes the first sample only; no checks.
  - Goes to TRACK on the next edge.
  - wrapped<=Ovf on that first sample, so monitoring can start mid-run.
- State TRACK: each edge, compares Gray against prev_gray using prev_en.
  - prev_en=1: expected = bin2gray(gray2bin(prev_gray)+1 mod 2^WIDTH).
    - Gray==prev_gray gives stall (01).
    - Any other Gray!=expected gives illegal step (10).
  - prev_en=0: Gray!=prev_gray gives illegal step (10).
  - Wrap: prev_gray=bin2gray(2^WIDTH-1) and Gray=0 with prev_en=1.
    - Wraps increments, saturating.
    - wrapped<=1.
  - Overflow rule: Ovf must equal wrapped (including a wrap detected this edge). Otherwise overflow mismatch (11).
  - Error priority when several occur in one cycle: 10 > 01 > 11.
  - On any error: go to ERROR, Err<=1, Err_code<=code, Locked<=0.
- State ERROR:
  - Err, Err_code and Wraps hold; Bin keeps tracking.
  - Leaves only on Clr or Reset.
- Clr (any state, synchronous): next state IDLE, Err=0, Err_code=00, Wraps=0, wrapped=0, Locked=0. Clr overrides a same-cycle error.
- Upstream counter reset (Gray forced to 0 without wrap) is an illegal step unless Clr is pulsed in the same cycle as that Reset.
- Locked=1 exactly while in TRACK, registered.
- Wraps at all-ones stays at all-ones on further wraps.
- Reset mid-operation is immediate and asynchronous; the first post-reset sample is unchecked.

Decomposition:
- Shared package gray_pkg:
  - state typedef {IDLE, TRACK, ERROR}.
  - error code constants ERR_NONE/STALL/STEP/OVF.
  - functions gray2bin and bin2gray, parameterised by WIDTH.
- One natural sub-module: gray_next. Combinational; takes prev_gray and returns the expected next gray code. Instantiated once.

Test Plan:
- Counter enabled from reset, sequence 000,001,011,010,110,111,101,100,000 with Ovf rising on the 000 after 100: Bin follows 0..7,0 one cycle late, Wraps=1, Locked=1, Err=0.
- En held 1 but Gray repeated 011,011: Err=1, Err_code=01 one edge after the repeat; Bin still updates; Locked=0.
- Gray jumps 001->010 with En=1: Err_code=10. Then Clr pulse: Err=0, Wraps=0, state IDLE, Locked=1 two edges later.
- Ovf asserted while Gray=011 with no wrap seen: Err_code=11. Separately, Ovf dropping to 0 after a wrap: Err_code=11.
- Simultaneous stall and Ovf mismatch: Err_code=01. Simultaneous illegal step and stall impossible; illegal step plus Ovf mismatch gives 10.
- Reset asserted mid-count between edges, with Gray at 110: all outputs are 0 immediately, without waiting for Clk. Checking resumes with no error when restarted at Gray=000. With CNTW=2, five wraps leave Wraps=3.
